slice_sequencer_n: RTL and testbench

- Per-slice control sequencer for the ProRes encoder pipeline.
- Runs the header phase, then NUM_COMP component phases (Y, Cb, Cr, optional alpha) in order.
- Advances on done handshakes from the header and component engines, not on fixed cycle counts.
- Accumulates per-phase byte sizes, then emits size patch-writes (slice, picture, frame, per-component) over a valid/ready port to the bitstream patcher.

---
 rtl/seq_pkg.sv | 46 ++++
 rtl/seq_patch_emitter.sv | 111 +++++++++++
 rtl/slice_sequencer_n.sv | 266 ++++++++++++++++++++++++++
 tb/tb_slice_sequencer_n.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared types and constants for slice_sequencer_n
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam int MAX_COMP = 4;

  localparam logic [2:0] SZ16 = 3'd2;
  localparam logic [2:0] SZ32 = 3'd4;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_IDLE     = 3'd0;
  localparam seq_state_t ST_HEADER   = 3'd1;
  localparam seq_state_t ST_COMP_GAP = 3'd2;
  localparam seq_state_t ST_COMP_RUN = 3'd3;
  localparam seq_state_t ST_CALC     = 3'd4;
  localparam seq_state_t ST_PATCH    = 3'd5;
  localparam seq_state_t ST_DONE     = 3'd6;

  typedef enum logic [1:0] {
    PK_SLICE   = 2'd0,
    PK_PICTURE = 2'd1,
    PK_FRAME   = 2'd2,
    PK_COMP    = 2'd3
  } patch_kind_e;

  // Patch table order is fixed: slice, picture, frame, then component sizes.
  function automatic patch_kind_e entry_kind(input int unsigned idx);
    case (idx)
      0:       return PK_SLICE;
      1:       return PK_PICTURE;
      2:       return PK_FRAME;
      default: return PK_COMP;
    endcase
  endfunction

  function automatic logic [2:0] kind_bytes(input patch_kind_e kind);
    return ((kind == PK_PICTURE) || (kind == PK_FRAME)) ? SZ32 : SZ16;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_patch_emitter.sv
// ============================================================================
// seq_patch_emitter : walks the latched patch table, skipping zero entries,
//                     and holds each write until the patcher accepts it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_patch_emitter
  import seq_pkg::*;
#(
  parameter int W     = 32,
  parameter int N_ENT = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [N_ENT-1:0][W-1:0]   ld_val,
  input  logic [N_ENT-1:0][W-1:0]   ld_addr,
  input  logic [N_ENT-1:0][2:0]     ld_bytes,
  input  logic                      wr_ready,
  output logic                      wr_valid,
  output logic [W-1:0]              wr_addr,
  output logic [W-1:0]              wr_val,
  output logic [2:0]                wr_bytes,
  output logic                      active,
  output logic                      last_accept
);

  localparam int IDXW = $clog2(N_ENT);

  logic [N_ENT-1:0][W-1:0] val_q, val_d;
  logic [N_ENT-1:0][W-1:0] addr_q, addr_d;
  logic [N_ENT-1:0][2:0]   bytes_q, bytes_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    active_q, active_d;

  logic [N_ENT-1:0]        ld_nz;
  logic [N_ENT-1:0]        rest_nz;
  logic                    ld_found;
  logic                    nx_found;
  logic [IDXW-1:0]         ld_idx;
  logic [IDXW-1:0]         nx_idx;
  logic                    accept;

  // Lowest set bit wins; MSB of the result flags "found".
  function automatic logic [IDXW:0] first_set(input logic [N_ENT-1:0] m);
    logic [IDXW:0] r;
    r = '0;
    for (int j = N_ENT - 1; j >= 0; j--) begin
      if (m[j]) r = {1'b1, IDXW'(j)};
    end
    return r;
  endfunction

  always_comb begin
    ld_nz   = '0;
    rest_nz = '0;
    for (int j = 0; j < N_ENT; j++) begin
      ld_nz[j]   = |ld_val[j];
      rest_nz[j] = (|val_q[j]) && (j > int'(idx_q));
    end
    {ld_found, ld_idx} = first_set(ld_nz);
    {nx_found, nx_idx} = first_set(rest_nz);

    accept      = active_q & wr_ready;
    last_accept = accept & ~nx_found;

    val_d    = val_q;
    addr_d   = addr_q;
    bytes_d  = bytes_q;
    idx_d    = idx_q;
    active_d = active_q;

    // Next index is chosen in the accept cycle, so skipped entries cost no bubble.
    if (load) begin
      val_d    = ld_val;
      addr_d   = ld_addr;
      bytes_d  = ld_bytes;
      idx_d    = ld_idx;
      active_d = ld_found;
    end else if (accept) begin
      if (nx_found) idx_d = nx_idx;
      else          active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= '0;
      addr_q   <= '0;
      bytes_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      addr_q   <= addr_d;
      bytes_q  <= bytes_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign wr_valid = active_q;
  assign wr_addr  = addr_q[idx_q];
  assign wr_val   = val_q[idx_q];
  assign wr_bytes = bytes_q[idx_q];
  assign active   = active_q;

endmodule

`default_nettype wire

// File: rtl/slice_sequencer_n.sv
// ============================================================================
// slice_sequencer_n : per-slice header/component phase sequencer with size
//                     patch-write emission. Optional macro: SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module slice_sequencer_n
  import seq_pkg::*;
#(
  parameter int NUM_COMP = 3,
  parameter int W        = 32,
  parameter int Y_BLOCKS = 32,
  parameter int C_BLOCKS = 16,
  parameter int C_BASE   = 2048,
  parameter int C_STRIDE = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          header_done,
  input  logic          comp_done,
  input  logic [W-1:0]  bit_total_byte_size,
  input  logic [W-1:0]  slice_size_table_size,
  input  logic [W-1:0]  slice_size_offset_addr,
  input  logic [W-1:0]  picture_size_offset_addr,
  input  logic [W-1:0]  frame_size_offset_addr,
  input  logic [W-1:0]  comp_size_base_addr,
`ifdef SEQ_TIMEOUT_EN
  input  logic [15:0]   hdr_budget,
  input  logic [15:0]   comp_budget,
  output logic          timeout_err,
`endif
  output logic          header_run,
  output logic          comp_run,
  output logic [1:0]    comp_idx,
  output logic          is_y,
  output logic [W-1:0]  offset,
  output logic [W-1:0]  block_num,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [W-1:0]  wr_addr,
  output logic [W-1:0]  wr_val,
  output logic [2:0]    wr_bytes,
  output logic          busy,
  output logic          done
);

  localparam int N_ENT = NUM_COMP + 2;

  seq_state_t                 state_q, state_d;
  logic [W-1:0]               base_q, base_d;
  logic [NUM_COMP-1:0][W-1:0] size_q, size_d;
  logic [1:0]                 idx_q, idx_d;
  logic                       header_run_q, header_run_d;
  logic                       comp_run_q, comp_run_d;
  logic [W-1:0]               offset_q, offset_d;
  logic [W-1:0]               block_num_q, block_num_d;
  logic                       is_y_q, is_y_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       hdr_evt;
  logic                       comp_evt;
  logic                       emit_active;
  logic                       emit_last;
  logic [W-1:0]               slice_v, picture_v, frame_v;
  logic [N_ENT-1:0][W-1:0]    ent_val, ent_addr;
  logic [N_ENT-1:0][2:0]      ent_bytes;

  function automatic logic [W-1:0] phase_offset(input logic [1:0] idx);
    if (idx == 2'd0) return '0;
    return W'(C_BASE) + W'(C_STRIDE) * W'(idx - 2'd1);
  endfunction

  function automatic logic [W-1:0] phase_blocks(input logic [1:0] idx);
    return (idx == 2'd0) ? W'(Y_BLOCKS) : W'(C_BLOCKS);
  endfunction

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] phase_cnt_q, phase_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        hdr_to, comp_to;

  // Counter reads 1 in the first cycle of a phase; a zero budget never expires.
  assign hdr_to   = (state_q == ST_HEADER)   && (hdr_budget  != 16'd0) && (phase_cnt_q == hdr_budget);
  assign comp_to  = (state_q == ST_COMP_RUN) && (comp_budget != 16'd0) && (phase_cnt_q == comp_budget);
  assign hdr_evt  = header_done | hdr_to;
  assign comp_evt = comp_done | comp_to;

  always_comb begin
    phase_cnt_d   = phase_cnt_q + 16'd1;
    timeout_err_d = timeout_err_q;
    if (((state_d == ST_HEADER) && (state_q != ST_HEADER)) ||
        ((state_d == ST_COMP_RUN) && (state_q != ST_COMP_RUN))) begin
      phase_cnt_d = 16'd1;
    end
    if ((state_q == ST_IDLE) && start)  timeout_err_d = 1'b0;
    if (hdr_to && !header_done)         timeout_err_d = 1'b1;
    if (comp_to && !comp_done)          timeout_err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      phase_cnt_q   <= phase_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign hdr_evt  = header_done;
  assign comp_evt = comp_done;
`endif

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    size_d       = size_q;
    idx_d        = idx_q;
    header_run_d = header_run_q;
    comp_run_d   = comp_run_q;
    offset_d     = offset_q;
    block_num_d  = block_num_q;
    is_y_d       = is_y_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_HEADER;
          header_run_d = 1'b1;
          busy_d       = 1'b1;
          base_d       = '0;
          size_d       = '0;
        end
      end
      ST_HEADER: begin
        if (hdr_evt) begin
          base_d       = bit_total_byte_size - slice_size_table_size;
          header_run_d = 1'b0;
          idx_d        = 2'd0;
          offset_d     = phase_offset(2'd0);
          block_num_d  = phase_blocks(2'd0);
          is_y_d       = 1'b1;
          state_d      = ST_COMP_GAP;
        end
      end
      ST_COMP_GAP: begin
        comp_run_d = 1'b1;
        state_d    = ST_COMP_RUN;
      end
      ST_COMP_RUN: begin
        if (comp_evt) begin
          size_d[idx_q] = bit_total_byte_size;
          comp_run_d    = 1'b0;
          if (idx_q < 2'(NUM_COMP - 1)) begin
            idx_d       = idx_q + 2'd1;
            offset_d    = phase_offset(idx_q + 2'd1);
            block_num_d = phase_blocks(idx_q + 2'd1);
            is_y_d      = 1'b0;
            state_d     = ST_COMP_GAP;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: state_d = ST_PATCH;
      ST_PATCH: begin
        if (emit_last || !emit_active) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Patch table is evaluated in CALC and captured by the emitter on the same edge.
  always_comb begin
    slice_v = base_q;
    for (int i = 0; i < NUM_COMP; i++) slice_v = slice_v + size_q[i];
    frame_v   = slice_v + slice_size_table_size;
    picture_v = frame_v - picture_size_offset_addr + W'(1);

    ent_val   = '0;
    ent_addr  = '0;
    ent_bytes = '0;
    ent_val[0]  = slice_v;
    ent_addr[0] = slice_size_offset_addr;
    ent_val[1]  = picture_v;
    ent_addr[1] = picture_size_offset_addr;
    ent_val[2]  = frame_v;
    ent_addr[2] = frame_size_offset_addr;
    for (int i = 0; i < NUM_COMP - 1; i++) begin
      ent_val[3+i]  = size_q[i];
      ent_addr[3+i] = comp_size_base_addr + W'(2 * i);
    end
    for (int j = 0; j < N_ENT; j++) ent_bytes[j] = kind_bytes(entry_kind(j));
  end

  seq_patch_emitter #(
    .W     (W),
    .N_ENT (N_ENT)
  ) u_emitter (
    .clk         (clock),
    .rst         (reset),
    .load        (state_q == ST_CALC),
    .ld_val      (ent_val),
    .ld_addr     (ent_addr),
    .ld_bytes    (ent_bytes),
    .wr_ready    (wr_ready),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_val      (wr_val),
    .wr_bytes    (wr_bytes),
    .active      (emit_active),
    .last_accept (emit_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      size_q       <= '0;
      idx_q        <= 2'd0;
      header_run_q <= 1'b0;
      comp_run_q   <= 1'b0;
      offset_q     <= '0;
      block_num_q  <= W'(Y_BLOCKS);
      is_y_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      size_q       <= size_d;
      idx_q        <= idx_d;
      header_run_q <= header_run_d;
      comp_run_q   <= comp_run_d;
      offset_q     <= offset_d;
      block_num_q  <= block_num_d;
      is_y_q       <= is_y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign header_run = header_run_q;
  assign comp_run   = comp_run_q;
  assign comp_idx   = idx_q;
  assign is_y       = is_y_q;
  assign offset     = offset_q;
  assign block_num  = block_num_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_slice_sequencer_n.sv
// ============================================================================
// tb_slice_sequencer_n : directed table-driven bench for slice_sequencer_n
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_slice_sequencer_n;

  localparam int W = 32;
  localparam logic [W-1:0] SLICE_A = 32'h0000_0004;
  localparam logic [W-1:0] PIC_A   = 32'h0000_0010;
  localparam logic [W-1:0] FRM_A   = 32'h0000_0014;
  localparam logic [W-1:0] CSZ_A   = 32'h0000_0040;

  typedef struct {
    logic [W-1:0]        hdr;
    logic [W-1:0]        tab;
    logic [3:0][W-1:0]   sz;
    int                  ncomp;
    int                  stall;
    int                  n_exp;
    logic [5:0][W-1:0]   ea;
    logic [5:0][W-1:0]   ev;
    logic [5:0][2:0]     eb;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1;
  logic          start3 = 1'b0, start4 = 1'b0;
  logic          header_done = 1'b0, comp_done = 1'b0;
  logic          wr_ready = 1'b1;
  logic [W-1:0]  total = '0, table_sz = '0;
  logic          sel4 = 1'b0;

  logic          hr3, cr3, y3, v3, b3, d3, hr4, cr4, y4, v4, b4, d4;
  logic [1:0]    ci3, ci4;
  logic [W-1:0]  of3, bn3, a3, vl3, of4, bn4, a4, vl4;
  logic [2:0]    by3, by4;

`ifdef SEQ_TIMEOUT_EN
  logic [15:0]   hdr_budget = 16'd0;
  logic [15:0]   comp_budget = 16'd100;
  logic          to3, to4;
`endif

  slice_sequencer_n #(.NUM_COMP(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3),
    .header_done(header_done), .comp_done(comp_done),
    .bit_total_byte_size(total), .slice_size_table_size(table_sz),
    .slice_size_offset_addr(SLICE_A), .picture_size_offset_addr(PIC_A),
    .frame_size_offset_addr(FRM_A), .comp_size_base_addr(CSZ_A),
`ifdef SEQ_TIMEOUT_EN
    .hdr_budget(hdr_budget), .comp_budget(comp_budget), .timeout_err(to3),
`endif
    .header_run(hr3), .comp_run(cr3), .comp_idx(ci3), .is_y(y3),
    .offset(of3), .block_num(bn3), .wr_valid(v3), .wr_ready(wr_ready),
    .wr_addr(a3), .wr_val(vl3), .wr_bytes(by3), .busy(b3), .done(d3)
  );

  slice_sequencer_n #(.NUM_COMP(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4),
    .header_done(header_done), .comp_done(comp_done),
    .bit_total_byte_size(total), .slice_size_table_size(table_sz),
    .slice_size_offset_addr(SLICE_A), .picture_size_offset_addr(PIC_A),
    .frame_size_offset_addr(FRM_A), .comp_size_base_addr(CSZ_A),
`ifdef SEQ_TIMEOUT_EN
    .hdr_budget(hdr_budget), .comp_budget(comp_budget), .timeout_err(to4),
`endif
    .header_run(hr4), .comp_run(cr4), .comp_idx(ci4), .is_y(y4),
    .offset(of4), .block_num(bn4), .wr_valid(v4), .wr_ready(wr_ready),
    .wr_addr(a4), .wr_val(vl4), .wr_bytes(by4), .busy(b4), .done(d4)
  );

  wire          m_hr   = sel4 ? hr4 : hr3;
  wire          m_cr   = sel4 ? cr4 : cr3;
  wire          m_y    = sel4 ? y4  : y3;
  wire          m_v    = sel4 ? v4  : v3;
  wire          m_busy = sel4 ? b4  : b3;
  wire          m_done = sel4 ? d4  : d3;
  wire [1:0]    m_ci   = sel4 ? ci4 : ci3;
  wire [W-1:0]  m_of   = sel4 ? of4 : of3;
  wire [W-1:0]  m_bn   = sel4 ? bn4 : bn3;
  wire [W-1:0]  m_a    = sel4 ? a4  : a3;
  wire [W-1:0]  m_vl   = sel4 ? vl4 : vl3;
  wire [2:0]    m_by   = sel4 ? by4 : by3;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [W-1:0] hdr, tab, s0, s1, s2, s3,
                               input int nc, input int st);
    vec_t v;
    v.hdr = hdr; v.tab = tab;
    v.sz[0] = s0; v.sz[1] = s1; v.sz[2] = s2; v.sz[3] = s3;
    v.ncomp = nc; v.stall = st; v.n_exp = 0;
    v.ea = '0; v.ev = '0; v.eb = '0;
    return v;
  endfunction

  function automatic vec_t addp(input vec_t v, input logic [W-1:0] a, input logic [W-1:0] val,
                                input logic [2:0] b);
    vec_t r;
    r = v;
    r.ea[r.n_exp] = a; r.ev[r.n_exp] = val; r.eb[r.n_exp] = b;
    r.n_exp++;
    return r;
  endfunction

  // Expected phase outputs for components 0..3.
  logic [3:0][W-1:0] exp_off;
  logic [3:0][W-1:0] exp_blk;

  task automatic pulse_start();
    if (sel4) start4 = 1'b1; else start3 = 1'b1;
    @(negedge clock);
    start3 = 1'b0; start4 = 1'b0;
  endtask

  task automatic drain(input vec_t v, input string tag);
    logic [5:0][W-1:0] ga, gv;
    logic [5:0][2:0]   gb;
    logic [W-1:0]      ha, hv;
    logic [2:0]        hb;
    logic              held;
    int np, sc, cyc, first_v, done_at;
    ga = '0; gv = '0; gb = '0; ha = '0; hv = '0; hb = '0; held = 1'b1;
    np = 0; sc = 0; cyc = 0; first_v = -1; done_at = -1;
    while (done_at < 0 && cyc < 400) begin
      if (m_done) begin
        done_at = cyc;
        chk({tag, " busy_at_done"}, W'(m_busy), W'(0));
      end else begin
        if (m_v) begin
          if (first_v < 0) first_v = cyc;
          if (sc == 0) begin
            ha = m_a; hv = m_vl; hb = m_by; held = 1'b1;
          end else if (m_a !== ha || m_vl !== hv || m_by !== hb) begin
            held = 1'b0;
          end
          if (sc < v.stall) begin
            wr_ready = 1'b0;
            sc++;
          end else begin
            wr_ready = 1'b1;
            if (np < 6) begin
              ga[np] = m_a; gv[np] = m_vl; gb[np] = m_by;
            end
            np++;
            if (v.stall > 0) chk({tag, " hold"}, W'(held), W'(1));
            sc = 0;
          end
        end else begin
          wr_ready = 1'b1;
        end
        @(negedge clock);
        cyc++;
      end
    end
    chk({tag, " done_seen"}, W'(done_at >= 0), W'(1));
    @(negedge clock);
    chk({tag, " done_one_cycle"}, W'(m_done), W'(0));
    chk({tag, " busy_after"}, W'(m_busy), W'(0));
    chk({tag, " n_patches"}, W'(np), W'(v.n_exp));
    for (int i = 0; i < v.n_exp && i < 6; i++) begin
      chk($sformatf("%s p%0d addr", tag, i), ga[i], v.ea[i]);
      chk($sformatf("%s p%0d val", tag, i), gv[i], v.ev[i]);
      chk($sformatf("%s p%0d bytes", tag, i), W'(gb[i]), W'(v.eb[i]));
    end
    if (v.stall == 0) chk({tag, " gapless"}, W'(done_at - first_v), W'(v.n_exp));
  endtask

  task automatic run_slice(input vec_t v, input string tag);
    sel4 = (v.ncomp == 4);
    table_sz = v.tab;
    @(negedge clock);
    pulse_start();
    chk({tag, " busy"}, W'(m_busy), W'(1));
    chk({tag, " header_run"}, W'(m_hr), W'(1));
    repeat (2) @(negedge clock);
    // comp_done alongside header_done must be ignored in HEADER.
    header_done = 1'b1; comp_done = 1'b1; total = v.hdr;
    @(negedge clock);
    header_done = 1'b0; comp_done = 1'b0; total = '0;
    chk({tag, " header_run_off"}, W'(m_hr), W'(0));
    for (int c = 0; c < v.ncomp; c++) begin
      chk($sformatf("%s c%0d gap", tag, c), W'(m_cr), W'(0));
      chk($sformatf("%s c%0d idx", tag, c), W'(m_ci), W'(c));
      @(negedge clock);
      chk($sformatf("%s c%0d run", tag, c), W'(m_cr), W'(1));
      chk($sformatf("%s c%0d offset", tag, c), m_of, exp_off[c]);
      chk($sformatf("%s c%0d blocks", tag, c), m_bn, exp_blk[c]);
      chk($sformatf("%s c%0d is_y", tag, c), W'(m_y), W'(c == 0));
      if (c == 0) pulse_start(); else @(negedge clock);
      @(negedge clock);
      comp_done = 1'b1; total = v.sz[c];
      @(negedge clock);
      comp_done = 1'b0; total = '0;
    end
    drain(v, tag);
  endtask

  vec_t vecs[4];

  initial begin
    exp_off[0] = 32'd0;    exp_off[1] = 32'd2048; exp_off[2] = 32'd3072; exp_off[3] = 32'd4096;
    exp_blk[0] = 32'd32;   exp_blk[1] = 32'd16;   exp_blk[2] = 32'd16;   exp_blk[3] = 32'd16;

    // Nominal Y/Cb/Cr.
    vecs[0] = mkv(32'h120, 32'h20, 32'h300, 32'h100, 32'h80, 32'h0, 3, 0);
    vecs[0] = addp(vecs[0], SLICE_A, 32'h580, 3'd2);
    vecs[0] = addp(vecs[0], PIC_A,   32'h591, 3'd4);
    vecs[0] = addp(vecs[0], FRM_A,   32'h5A0, 3'd4);
    vecs[0] = addp(vecs[0], 32'h40,  32'h300, 3'd2);
    vecs[0] = addp(vecs[0], 32'h42,  32'h100, 3'd2);
    // Backpressure: same payloads, 5 stall cycles per entry.
    vecs[1] = vecs[0];
    vecs[1].stall = 5;
    // Cb size zero is skipped.
    vecs[2] = mkv(32'h120, 32'h20, 32'h300, 32'h0, 32'h80, 32'h0, 3, 0);
    vecs[2] = addp(vecs[2], SLICE_A, 32'h480, 3'd2);
    vecs[2] = addp(vecs[2], PIC_A,   32'h491, 3'd4);
    vecs[2] = addp(vecs[2], FRM_A,   32'h4A0, 3'd4);
    vecs[2] = addp(vecs[2], 32'h40,  32'h300, 3'd2);
    // Four components with alpha.
    vecs[3] = mkv(32'h120, 32'h20, 32'h300, 32'h100, 32'h80, 32'h40, 4, 0);
    vecs[3] = addp(vecs[3], SLICE_A, 32'h5C0, 3'd2);
    vecs[3] = addp(vecs[3], PIC_A,   32'h5D1, 3'd4);
    vecs[3] = addp(vecs[3], FRM_A,   32'h5E0, 3'd4);
    vecs[3] = addp(vecs[3], 32'h40,  32'h300, 3'd2);
    vecs[3] = addp(vecs[3], 32'h42,  32'h100, 3'd2);
    vecs[3] = addp(vecs[3], 32'h44,  32'h80,  3'd2);

    repeat (3) @(negedge clock);
    chk("rst header_run", W'(hr3), W'(0));
    chk("rst comp_run", W'(cr3), W'(0));
    chk("rst comp_idx", W'(ci3), W'(0));
    chk("rst is_y", W'(y3), W'(1));
    chk("rst offset", of3, W'(0));
    chk("rst block_num", bn3, W'(32));
    chk("rst wr_valid", W'(v3), W'(0));
    chk("rst busy", W'(b3), W'(0));
    chk("rst done", W'(d3), W'(0));
    chk("rst4 block_num", bn4, W'(32));
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_slice(vecs[i], $sformatf("v%0d", i));

    // Reset while component 0 is running.
    sel4 = 1'b0;
    table_sz = 32'h20;
    @(negedge clock);
    pulse_start();
    header_done = 1'b1; total = 32'h120;
    @(negedge clock);
    header_done = 1'b0;
    @(negedge clock);
    chk("mid comp_run", W'(cr3), W'(1));
    reset = 1'b1;
    @(negedge clock);
    chk("mid rst comp_run", W'(cr3), W'(0));
    chk("mid rst busy", W'(b3), W'(0));
    chk("mid rst is_y", W'(y3), W'(1));
    chk("mid rst block_num", bn3, W'(32));
    chk("mid rst offset", of3, W'(0));
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("mid no wr_valid", W'(v3), W'(0));
      chk("mid idle busy", W'(b3), W'(0));
    end
    run_slice(vecs[0], "after_rst");

`ifdef SEQ_TIMEOUT_EN
    begin : t_timeout
      int runc;
      int cyc;
      runc = 0;
      sel4 = 1'b0;
      @(negedge clock);
      pulse_start();
      header_done = 1'b1; total = 32'h120;
      @(negedge clock);
      header_done = 1'b0; total = 32'h300;
      @(negedge clock);
      while (cr3 && runc < 200) begin
        runc++;
        @(negedge clock);
      end
      chk("to run cycles", W'(runc), W'(100));
      chk("to err", W'(to3), W'(1));
      cyc = 0;
      while (!d3 && cyc < 400) begin
        comp_done = cr3;
        wr_ready = 1'b1;
        @(negedge clock);
        cyc++;
      end
      comp_done = 1'b0;
      chk("to done seen", W'(d3), W'(1));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
